// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetch unit: buffer entry layout and fetch FSM states.
// The PC step helper keeps the wrap-around increment in one place.
package fetch_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/wishbone_if.sv
// 32-bit Wishbone-style bus bundle; the prefetcher uses the master view read-only.
// data_out is the slave's read data, returned together with ack.
interface wishbone_if;
  logic        cycle;
  logic        strobe;
  logic        write_enable;
  logic [3:0]  byte_select;
  logic [31:0] address;
  logic        ack;
  logic [31:0] data_out;

  modport master (
    output cycle, strobe, write_enable, byte_select, address,
    input  ack, data_out
  );

  modport slave (
    input  cycle, strobe, write_enable, byte_select, address,
    output ack, data_out
  );
endinterface

// File: rtl/prefetch_fifo.sv
// Prefetch buffer: synchronous FIFO of fetch entries, flush wins over push/pop, zero-latency head.
// Push is accepted when not full or when a pop frees a slot in the same cycle.
module prefetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instruction_prefetch.sv
// Instruction prefetcher: one bus read per 3 cycles into a FIFO, branch flushes; stall holds the head.
// Define PREFETCH_TIMEOUT_EN to abandon and reissue a read after TIMEOUT_CYCLES without ack.
module instruction_prefetch
  import fetch_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  wishbone_if.master  wishbone_bus,
  input  logic        i_branch_enable,
  input  logic [31:0] i_branch_address,
  input  logic        i_stall,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic        o_instruction_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  bus_addr_q, bus_addr_d;
  logic         bus_active;
  logic         bus_ack;
  logic         tmo_hit;
  logic         push;
  logic         pop;
  logic         has_room;
  logic         fifo_empty;
  fetch_entry_t fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic         unused_ok;

  assign bus_active = (state_q != IDLE);
  // An ack outside an active cycle belongs to nobody and is dropped.
  assign bus_ack    = bus_active && wishbone_bus.ack;
  assign has_room   = (fifo_count != ($clog2(FIFO_DEPTH) + 1)'(FIFO_DEPTH));

  assign wishbone_bus.cycle        = bus_active;
  assign wishbone_bus.strobe       = bus_active;
  assign wishbone_bus.write_enable = 1'b0;
  assign wishbone_bus.byte_select  = 4'hF;
  assign wishbone_bus.address      = bus_active ? bus_addr_q : 32'h0;

`ifdef PREFETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d   = '0;
    tmo_hit = 1'b0;
    if (bus_active && !bus_ack) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) tmo_hit = 1'b1;
      else                                  tmo_d   = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign unused_ok = ^{i_branch_address[1:0], (TIMEOUT_CYCLES > 0)};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    bus_addr_d = bus_addr_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!i_branch_enable && has_room) begin
          state_d    = REQ;
          bus_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (bus_ack) begin
          state_d = IDLE;
          if (!i_branch_enable) begin
            push       = 1'b1;
            fetch_pc_d = next_pc(fetch_pc_q);
          end
        end else if (i_branch_enable) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (bus_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Timeout returns to IDLE with fetch PC untouched, so the same word is requested again.
    if (tmo_hit) state_d = IDLE;
    if (i_branch_enable) fetch_pc_d = {i_branch_address[31:2], 2'b00};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      bus_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      bus_addr_q <= bus_addr_d;
    end
  end

  assign pop = o_instruction_valid && !i_stall && !i_branch_enable;

  prefetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (i_branch_enable),
    .push      (push),
    .push_data ('{pc: bus_addr_q, instruction: wishbone_bus.data_out}),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign o_instruction_valid = !fifo_empty;
  assign o_instruction       = o_instruction_valid ? fifo_head.instruction : 32'h0;
  assign o_pc                = o_instruction_valid ? fifo_head.pc : 32'h0;

endmodule

// File: tb/tb_instruction_prefetch.sv
// Directed bench: one-cycle-ack slave returning 00AA0000 + word index, hand-timed checks per scenario.
module tb_instruction_prefetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_branch_enable = 1'b0;
  logic [31:0] i_branch_address = 32'h0;
  logic        i_stall = 1'b0;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic        o_instruction_valid;
  logic        hold = 1'b0;
  int          reads = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  wishbone_if wb ();

  instruction_prefetch dut (
    .clk                 (clk),
    .reset               (reset),
    .wishbone_bus        (wb),
    .i_branch_enable     (i_branch_enable),
    .i_branch_address    (i_branch_address),
    .i_stall             (i_stall),
    .o_instruction       (o_instruction),
    .o_pc                (o_pc),
    .o_instruction_valid (o_instruction_valid)
  );

  always #5 clk = ~clk;

  // Slave: registered ack one cycle after strobe, suppressed while hold is set.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wb.ack      <= 1'b0;
      wb.data_out <= 32'h0;
    end else begin
      wb.ack      <= wb.cycle && wb.strobe && !wb.ack && !hold;
      wb.data_out <= 32'h00AA0000 + {2'b00, wb.address[31:2]};
      if (wb.cycle && wb.strobe && wb.ack) reads <= reads + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    chk({tag, "_valid"}, {31'b0, o_instruction_valid}, 32'd1);
    chk({tag, "_pc"}, o_pc, pc);
    chk({tag, "_instr"}, o_instruction, instr);
  endtask

  initial begin
    int base;
    logic exp_cyc;

    // Reset state
    tick(1);
    chk("rst_valid", {31'b0, o_instruction_valid}, 32'd0);
    chk("rst_cyc", {31'b0, wb.cycle}, 32'd0);
    chk("rst_stb", {31'b0, wb.strobe}, 32'd0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_instr", o_instruction, 32'h0);
    chk("rst_addr", wb.address, 32'h0);

    // Basic streaming, no stall
    reset = 1'b0;
    tick(1);
    chk("t1_req_cyc", {31'b0, wb.cycle}, 32'd1);
    chk("t1_req_addr", wb.address, 32'h0);
    chk("t1_we", {31'b0, wb.write_enable}, 32'd0);
    chk("t1_sel", {28'b0, wb.byte_select}, 32'hF);
    tick(1);
    chk("t1_wait_valid", {31'b0, o_instruction_valid}, 32'd0);
    tick(1);
    chk_head("t1_first", 32'h0, 32'h00AA0000);
    chk("t1_gap_cyc", {31'b0, wb.cycle}, 32'd0);
    tick(1);
    chk("t1_popped", {31'b0, o_instruction_valid}, 32'd0);
    chk("t1_req2_addr", wb.address, 32'h4);
    tick(2);
    chk_head("t1_second", 32'h4, 32'h00AA0001);

    // Stall fills the buffer, then drains in order
    i_stall = 1'b1;
    base = reads;
    do_reset();
    tick(40);
    chk("t2_reads", reads - base, 32'd4);
    chk("t2_bus_idle", {31'b0, wb.cycle}, 32'd0);
    i_stall = 1'b0;
    chk_head("t2_h0", 32'h0, 32'h00AA0000);
    tick(1);
    chk_head("t2_h1", 32'h4, 32'h00AA0001);
    tick(1);
    chk_head("t2_h2", 32'h8, 32'h00AA0002);
    tick(1);
    chk_head("t2_h3", 32'hC, 32'h00AA0003);
    tick(1);
    chk_head("t2_h4", 32'h10, 32'h00AA0004);

    // Branch while REQ awaits ack
    hold = 1'b1;
    do_reset();
    tick(1);
    chk("t3_req_addr", wb.address, 32'h0);
    i_branch_enable = 1'b1;
    i_branch_address = 32'h20;
    tick(1);
    i_branch_enable = 1'b0;
    chk("t3_discard_cyc", {31'b0, wb.cycle}, 32'd1);
    chk("t3_discard_addr", wb.address, 32'h0);
    chk("t3_discard_valid", {31'b0, o_instruction_valid}, 32'd0);
    hold = 1'b0;
    tick(1);
    chk("t3_ack_valid", {31'b0, o_instruction_valid}, 32'd0);
    tick(1);
    chk("t3_drop_valid", {31'b0, o_instruction_valid}, 32'd0);
    chk("t3_drop_cyc", {31'b0, wb.cycle}, 32'd0);
    tick(1);
    chk("t3_refetch_addr", wb.address, 32'h20);
    tick(1);
    chk("t3_wait_valid", {31'b0, o_instruction_valid}, 32'd0);
    tick(1);
    chk_head("t3_target", 32'h20, 32'h00AA0008);

    // Branch coincident with ack and pop; low address bits ignored
    i_stall = 1'b1;
    do_reset();
    tick(5);
    chk_head("t4_pre", 32'h0, 32'h00AA0000);
    chk("t4_pre_addr", wb.address, 32'h4);
    i_stall = 1'b0;
    i_branch_enable = 1'b1;
    i_branch_address = 32'h23;
    tick(1);
    i_branch_enable = 1'b0;
    chk("t4_flush_valid", {31'b0, o_instruction_valid}, 32'd0);
    chk("t4_flush_cyc", {31'b0, wb.cycle}, 32'd0);
    tick(1);
    chk("t4_next_addr", wb.address, 32'h20);
    tick(2);
    chk_head("t4_target", 32'h20, 32'h00AA0008);
    tick(1);
    chk("t4_count_empty", {31'b0, o_instruction_valid}, 32'd0);
    chk("t4_next_seq_addr", wb.address, 32'h24);

    // Slave withholds ack for 20 cycles
    hold = 1'b1;
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      tick(1);
`ifdef PREFETCH_TIMEOUT_EN
      exp_cyc = (i != 17);
`else
      exp_cyc = 1'b1;
`endif
      chk($sformatf("t5_cyc_%0d", i), {31'b0, wb.cycle}, {31'b0, exp_cyc});
      chk($sformatf("t5_addr_%0d", i), wb.address, 32'h0);
    end
    chk("t5_wait_valid", {31'b0, o_instruction_valid}, 32'd0);
    hold = 1'b0;
    tick(2);
    chk_head("t5_done", 32'h0, 32'h00AA0000);

    // Async reset in the middle of a request
    i_stall = 1'b1;
    do_reset();
    tick(4);
    chk_head("t6_pre", 32'h0, 32'h00AA0000);
    chk("t6_pre_cyc", {31'b0, wb.cycle}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_cyc", {31'b0, wb.cycle}, 32'd0);
    chk("t6_async_stb", {31'b0, wb.strobe}, 32'd0);
    chk("t6_async_valid", {31'b0, o_instruction_valid}, 32'd0);
    chk("t6_async_pc", o_pc, 32'h0);
    chk("t6_async_addr", wb.address, 32'h0);
    tick(1);
    reset = 1'b0;
    i_stall = 1'b0;
    tick(1);
    chk("t6_restart_cyc", {31'b0, wb.cycle}, 32'd1);
    chk("t6_restart_addr", wb.address, 32'h0);
    tick(2);
    chk_head("t6_restart", 32'h0, 32'h00AA0000);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/instruction_prefetch.md
INSTRUCTION_PREFETCH -- requirements
Module: instruction_prefetch

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: prefetch buffer entries; power of two, >= 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Parameter TIMEOUT_CYCLES, default 16: ack wait limit; used only under REQ-027.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 wishbone_bus  wishbone_if.master  --  32-bit instruction read port (cycle, strobe, address, ack, data_out).
REQ-007 i_branch_enable  input  1  redirect request; flush and refetch from i_branch_address.
REQ-008 i_branch_address  input  32  redirect target; bits [1:0] ignored.
REQ-009 i_stall  input  1  consumer not accepting; head entry held.
REQ-010 o_instruction  output  32  head-of-buffer instruction word.
REQ-011 o_pc  output  32  byte address of o_instruction.
REQ-012 o_instruction_valid  output  1  head entry present.

Function
REQ-013 Bus is read-only: write enable held 0, full byte select, address word-aligned (bits [1:0] = 0).
REQ-014 FSM states IDLE, REQ, DISCARD; cycle = strobe = 1 exactly in REQ and DISCARD.
REQ-015 IDLE -> REQ when buffer count < FIFO_DEPTH and no branch this cycle, address = fetch PC.
REQ-016 REQ: ack counted only while strobe high; on ack push {fetch PC, data_out}, fetch PC += 4 (wraps 32'hFFFF_FFFC -> 0), go IDLE.
REQ-017 After every accepted ack, strobe stays low for exactly one cycle before the next request; ack seen in IDLE is ignored.
REQ-018 o_instruction_valid = buffer non-empty; o_instruction/o_pc = head entry, zero when empty.
REQ-019 Pop when o_instruction_valid && !i_stall; push and pop in the same cycle allowed, count unchanged.
REQ-020 Full buffer: no new request; an in-flight request still completes and pushes (credit rule guarantees room).
REQ-021 Branch (any state, regardless of i_stall): buffer flushed at the edge, o_instruction_valid = 0 next cycle, fetch PC = {i_branch_address[31:2], 2'b00}.
REQ-022 Branch in REQ without ack -> DISCARD; DISCARD holds cycle/strobe until ack, drops the data, then -> IDLE.
REQ-023 Branch in REQ coincident with ack: data dropped, -> IDLE; branch in DISCARD: fetch PC updated again, stays DISCARD.
REQ-024 Branch takes priority over coincident pop and push.
REQ-025 Latency: first request in the first cycle after reset deassertion; with a one-cycle-ack slave, first valid 2 cycles after request; sustained rate one word per 3 cycles.

Reset
REQ-026 Asserted reset immediately forces: IDLE, cycle = strobe = 0, buffer empty, fetch PC = RESET_PC, all outputs 0; mid-transaction reset abandons the bus cycle.

Configuration
REQ-027 Macro PREFETCH_TIMEOUT_EN defined: in REQ or DISCARD, TIMEOUT_CYCLES cycles without ack -> cycle/strobe low one cycle, then REQ reissues the same address (DISCARD -> IDLE, no data).
REQ-028 PREFETCH_TIMEOUT_EN undefined: no timeout counter; master waits for ack indefinitely; TIMEOUT_CYCLES unused.

Structure
REQ-029 Shared package fetch_pkg holds fetch_entry_t (pc, instruction) and fetch_state_e (IDLE, REQ, DISCARD).
REQ-030 Buffer is sub-module prefetch_fifo (synchronous, parametrised depth, flush input, count output); FSM and PC logic in instruction_prefetch.

Verification
REQ-031 Slave word i = 32'h00AA0000 + i, one-cycle ack; reset release, no stall -> valid PC=0 instr 00AA0000, then PC=4 instr 00AA0001.
REQ-032 i_stall held 40 cycles, FIFO_DEPTH=4 -> exactly 4 bus reads then bus idle; on release, 4 consecutive valid cycles PC 0,4,8,C.
REQ-033 Branch to 0x20 while REQ awaits ack -> in-flight word dropped, next valid PC=0x20 instr 00AA0008, no stale PC ever valid.
REQ-034 Branch coincident with ack and pop -> buffer empty next cycle, next read address 0x20, count never corrupt.
REQ-035 Slave withholds ack 20 cycles -> with PREFETCH_TIMEOUT_EN, reissue of same address at cycle 16 plus one idle cycle; without, single wait then normal completion.
REQ-036 Async reset asserted mid-REQ -> cycle/strobe low and valid 0 before next clock edge; restart from RESET_PC.
